// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// IF/ID/EX/MEM/WB and drives every datapath strobe and mux select.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   opcode, bcond          IR[6:0] and branch comparator result
//   ecall_halt, mem_ready  halt request at ECALL, memory completion
//   i_or_d .. pc_source    datapath strobes and selects
//   halted, mem_err        sticky halt and memory-timeout flags
//   cycle_count            cycles since reset, frozen while halted
//   retired_count          retired instructions
module multicycle_control_fsm #(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             ecall_halt,
    input  logic             mem_ready,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             pc_write,
    output logic             pc_source,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_ST   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_SYS  = 7'h73;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_FN  = 2'd1;
    localparam logic [1:0] ALU_BR  = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] wait_cnt;
    logic        wait_hit;
    logic        timeout;
    logic        halt_ecall;

    logic is_r, is_i, is_ld, is_st;
    logic is_br, is_jal, is_jalr, is_sys;
    logic known;

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_sys  = (opcode == OP_SYS);
    assign known   = is_r | is_i | is_ld | is_st
                   | is_br | is_jal | is_jalr | is_sys;

    // This cycle would be the MEM_WAIT_MAX-th stalled cycle.
    assign wait_hit = (MEM_WAIT_MAX != 0)
                   && (wait_cnt + 32'd1 == 32'(MEM_WAIT_MAX));

    assign halted = (state == S_HALT);

    always_comb begin
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_I;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        timeout    = 1'b0;
        halt_ecall = 1'b0;
        state_nx   = state;

        unique case (state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_nx = S_ID;
                end else if (wait_hit) begin
                    timeout  = 1'b1;
                    state_nx = S_HALT;
                end
            end
            S_ID: begin
                // ALUOut <= PC + imm, the branch/JAL target.
                alu_src_b = 1'b1;
                imm_sel   = is_jal ? IMM_J : IMM_B;
                if (is_sys) begin
                    if (ecall_halt) begin
                        halt_ecall = 1'b1;
                        state_nx   = S_HALT;
                    end else begin
                        pc_write = 1'b1;
                        state_nx = S_IF;
                    end
                end else if (!known) begin
                    pc_write = 1'b1;
                    state_nx = S_IF;
                end else begin
                    state_nx = S_EX;
                end
            end
            S_EX: begin
                state_nx = S_IF;
                if (is_r) begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FN;
                    state_nx  = S_WB;
                end else if (is_i) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    alu_op    = ALU_FN;
                    state_nx  = S_WB;
                end else if (is_ld || is_st) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    imm_sel   = is_st ? IMM_S : IMM_I;
                    state_nx  = S_MEM;
                end else if (is_br) begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_BR;
                    pc_write  = 1'b1;
                    pc_source = bcond;
                end else if (is_jal) begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                end else if (is_jalr) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    state_nx  = S_WB;
                end
            end
            S_MEM: begin
                i_or_d   = 1'b1;
                state_nx = S_IF;
                if (is_ld || is_st) begin
                    mem_read  = is_ld;
                    mem_write = is_st;
                    state_nx  = S_MEM;
                    if (mem_ready) begin
                        pc_write = is_st;
                        state_nx = is_ld ? S_WB : S_IF;
                    end else if (wait_hit) begin
                        timeout  = 1'b1;
                        state_nx = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = is_ld ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                // The datapath clears bit 0 of the JALR target.
                pc_source = is_jalr;
                state_nx  = S_IF;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IF;
            end
        endcase

        // Reset abandons any access in flight.
        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            wb_sel     = 2'd0;
            i_or_d     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 1'b0;
            alu_op     = ALU_ADD;
            imm_sel    = IMM_I;
            pc_write   = 1'b0;
            pc_source  = 1'b0;
            timeout    = 1'b0;
            halt_ecall = 1'b0;
            state_nx   = S_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IF;
            wait_cnt      <= 32'd0;
            mem_err       <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state
                && (state_nx == S_IF || state_nx == S_MEM)) begin
                wait_cnt <= 32'd0;
            end else if ((mem_read || mem_write) && !mem_ready) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (state != S_HALT) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (pc_write || halt_ecall) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: plans each instruction's
// cycle sequence from its latency rules and checks every cycle.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_ST   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_SYS  = 7'h73;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    typedef enum {P_RST, P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT} ph_t;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_sel;
        logic       pc_write;
        logic       pc_source;
        logic       halted;
        logic       mem_err;
    } ov_t;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        bcond;
    logic        ecall_halt;
    logic        mem_ready;
    logic        i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  wb_sel;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  imm_sel;
    logic        pc_write, pc_source, halted, mem_err;
    logic [31:0] cycle_count, retired_count;

    multicycle_control_fsm #(.CNT_W(32), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_sel(imm_sel), .pc_write(pc_write), .pc_source(pc_source),
        .halted(halted), .mem_err(mem_err), .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ov_t         act;
    ov_t         exp_o;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ret;
    logic        h_m;
    logic        m_err;
    logic        chk;
    string       tag;
    int          n_vec;
    int          n_bad;

    assign act = {i_or_d, mem_read, mem_write, ir_write, reg_write,
                  wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel,
                  pc_write, pc_source, halted, mem_err};

    function automatic logic known(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST,
                          OP_BR, OP_JAL, OP_JALR, OP_SYS};
    endfunction

    // Expected outputs for one cycle of a given instruction phase.
    function automatic ov_t ev(ph_t ph, logic [6:0] op, logic rdy,
                               logic bc, logic eh, logic hm, logic me);
        ov_t o;
        o = '0;
        case (ph)
            P_RST: begin
                o.halted  = hm;
                o.mem_err = me;
            end
            P_IF: begin
                o.mem_read = 1'b1;
                o.ir_write = rdy;
            end
            P_ID: begin
                o.alu_src_b = 1'b1;
                o.imm_sel   = (op == OP_JAL) ? 3'd4 : 3'd2;
                if ((op == OP_SYS && !eh) || !known(op))
                    o.pc_write = 1'b1;
            end
            P_EX: begin
                case (op)
                    OP_R:    begin o.alu_src_a = 1; o.alu_op = 2'd1; end
                    OP_I:    begin
                        o.alu_src_a = 1; o.alu_src_b = 1; o.alu_op = 2'd1;
                    end
                    OP_LD:   begin o.alu_src_a = 1; o.alu_src_b = 1; end
                    OP_ST:   begin
                        o.alu_src_a = 1; o.alu_src_b = 1; o.imm_sel = 3'd1;
                    end
                    OP_BR:   begin
                        o.alu_src_a = 1; o.alu_op = 2'd2;
                        o.pc_write = 1; o.pc_source = bc;
                    end
                    OP_JAL:  begin
                        o.reg_write = 1; o.wb_sel = 2'd2;
                        o.pc_write = 1; o.pc_source = 1;
                    end
                    OP_JALR: begin o.alu_src_a = 1; o.alu_src_b = 1; end
                    default: ;
                endcase
            end
            P_MEM: begin
                o.i_or_d    = 1'b1;
                o.mem_read  = (op == OP_LD);
                o.mem_write = (op == OP_ST);
                o.pc_write  = (op == OP_ST) && rdy;
            end
            P_WB: begin
                o.reg_write = 1'b1;
                o.pc_write  = 1'b1;
                o.wb_sel    = (op == OP_LD) ? 2'd1
                            : (op == OP_JALR) ? 2'd2 : 2'd0;
                o.pc_source = (op == OP_JALR);
            end
            P_HALT: begin
                o.halted  = 1'b1;
                o.mem_err = me;
            end
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            n_vec++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL strobes[%s] t=%0t got %h want %h",
                         tag, $time, act, exp_o);
            end
            n_vec++;
            if (cycle_count !== exp_cyc) begin
                n_bad++;
                $display("FAIL cycle_count[%s] got %0d want %0d",
                         tag, cycle_count, exp_cyc);
            end
            n_vec++;
            if (retired_count !== exp_ret) begin
                n_bad++;
                $display("FAIL retired_count[%s] got %0d want %0d",
                         tag, retired_count, exp_ret);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    // One clock cycle: drive, publish expectation, advance the model.
    task automatic cyc(input ph_t ph, input logic rst, input logic rdy,
                       input logic ret);
        ov_t e;
        reset     = rst;
        mem_ready = rdy;
        e = ev(rst ? P_RST : ph, opcode, rdy, bcond, ecall_halt,
               h_m, m_err);
        exp_o = e;
        tag   = ph.name();
        chk   = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_cyc = 0;
            exp_ret = 0;
            h_m     = 1'b0;
            m_err   = 1'b0;
        end else begin
            if (ph != P_HALT) exp_cyc++;
            if (e.pc_write || ret) exp_ret++;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(P_RST, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic run(input logic [6:0] op, input logic bc,
                       input logic eh, input int ifw, input int mw);
        opcode     = op;
        bcond      = bc;
        ecall_halt = eh;
        for (int i = 0; i <= ifw; i++) cyc(P_IF, 1'b0, i == ifw, 1'b0);
        cyc(P_ID, 1'b0, 1'b1, op == OP_SYS && eh);
        if (op == OP_SYS && eh) h_m = 1'b1;
        if (op == OP_SYS || !known(op)) return;
        cyc(P_EX, 1'b0, 1'b1, 1'b0);
        if (op == OP_BR || op == OP_JAL) return;
        if (op == OP_LD || op == OP_ST)
            for (int i = 0; i <= mw; i++) cyc(P_MEM, 1'b0, i == mw, 1'b0);
        if (op == OP_ST) return;
        cyc(P_WB, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            opcode     = 7'($urandom);
            bcond      = 1'($urandom);
            ecall_halt = 1'($urandom);
            cyc(P_HALT, 1'b0, 1'($urandom), 1'b0);
        end
    endtask

    logic [31:0] c0;
    logic [31:0] r0;

    initial begin
        n_vec = 0; n_bad = 0; chk = 1'b0;
        exp_cyc = 0; exp_ret = 0; h_m = 1'b0; m_err = 1'b0;
        exp_o = '0; tag = "init";
        reset = 1'b1; opcode = OP_R; bcond = 1'b0;
        ecall_halt = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // First cycle out of reset with memory ready.
        reset = 1'b0; mem_ready = 1'b1; opcode = OP_R;
        #1;
        lit("c1_mem_read", 32'(mem_read), 32'd1);
        lit("c1_ir_write", 32'(ir_write), 32'd1);
        lit("c1_reg_write", 32'(reg_write), 32'd0);

        run(OP_R, 1'b0, 1'b0, 0, 0);
        lit("add_retired", retired_count, 32'd1);
        lit("add_cycles", cycle_count, 32'd4);

        // Three IF stalls stays under the timeout of four.
        run(OP_I, 1'b0, 1'b0, 3, 0);
        lit("addi_stall_err", 32'(mem_err), 32'd0);

        c0 = cycle_count;
        run(OP_LD, 1'b0, 1'b0, 0, 3);
        lit("load_w3_cycles", cycle_count - c0, 32'd8);

        c0 = cycle_count;
        run(OP_ST, 1'b0, 1'b0, 0, 0);
        lit("store_cycles", cycle_count - c0, 32'd4);

        c0 = cycle_count;
        run(OP_BR, 1'b1, 1'b0, 0, 0);
        run(OP_BR, 1'b0, 1'b0, 0, 0);
        lit("branch2_cycles", cycle_count - c0, 32'd6);

        run(OP_JAL, 1'b0, 1'b0, 0, 0);
        run(OP_JALR, 1'b0, 1'b0, 1, 0);
        run(OP_BAD, 1'b0, 1'b0, 0, 0);
        c0 = cycle_count;
        run(OP_SYS, 1'b0, 1'b0, 0, 0);
        lit("ecall_go_cycles", cycle_count - c0, 32'd2);
        lit("retired_mid", retired_count, 32'd10);

        // Reset while a store waits in MEM.
        opcode = OP_ST; bcond = 1'b0; ecall_halt = 1'b0;
        cyc(P_IF, 1'b0, 1'b1, 1'b0);
        cyc(P_ID, 1'b0, 1'b1, 1'b0);
        cyc(P_EX, 1'b0, 1'b1, 1'b0);
        cyc(P_MEM, 1'b0, 1'b0, 1'b0);
        cyc(P_MEM, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        run(OP_R, 1'b0, 1'b0, 0, 0);
        lit("post_rst_retired", retired_count, 32'd1);

        // Halting ECALL: HALT in the third cycle.
        c0 = cycle_count;
        r0 = retired_count;
        run(OP_SYS, 1'b0, 1'b1, 0, 0);
        lit("ecall_halted", 32'(halted), 32'd1);
        lit("ecall_retired", retired_count - r0, 32'd1);
        halt_cycles(3);
        lit("ecall_frozen", cycle_count - c0, 32'd2);
        do_reset(2);

        // Instruction fetch never completes.
        opcode = OP_R;
        for (int i = 0; i < 4; i++) cyc(P_IF, 1'b0, 1'b0, 1'b0);
        h_m = 1'b1;
        m_err = 1'b1;
        lit("tmo_mem_err", 32'(mem_err), 32'd1);
        lit("tmo_halted", 32'(halted), 32'd1);
        lit("tmo_cycles", cycle_count, 32'd4);
        halt_cycles(3);
        lit("tmo_frozen", cycle_count, 32'd4);
        lit("tmo_retired", retired_count, 32'd0);

        do_reset(2);
        run(OP_LD, 1'b0, 1'b0, 0, 0);
        lit("recover_retired", retired_count, 32'd1);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
